// File: rtl/flag_branch_unit.sv
// flag_branch_unit
//   Consumer end of the ALU status flags. Holds the architectural NZVC
//   register, evaluates LEGv8 branch conditions (B.cond, CBZ, CBNZ, B) and
//   presents a registered taken/taken_valid pair to the PC-select logic. It
//   also keeps saturating counts of evaluated and taken branches.
//
// Parameters
//   FLAG_FWD  1: a B.cond issued with set_flags sees the live ALU flags,
//             0: it sees the stored flags_q
//   CNT_W     width of branch_count / taken_count
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   alu_negative/zero/overflow/carry_out   live ALU flags
//   set_flags         latch live flags into flags_q at this edge
//   br_valid          branch decision requested this cycle
//   br_kind           00 B.cond, 01 CBZ, 10 CBNZ, 11 B
//   br_cond           ARM condition code (B.cond only)
//   flags_q           stored {N,Z,V,C}
//   taken             registered decision (holds when no branch is evaluated)
//   taken_valid       result strobe
//   branch_count      evaluated branches, saturating
//   taken_count       taken branches, saturating
//
// Handshake: br_valid/taken_valid is a valid-only pipe with no ready. Every
// br_valid accepted at an edge (reset low) yields exactly one taken_valid=1
// cycle immediately after; back-to-back requests give back-to-back results.
module flag_branch_unit #(
  parameter int unsigned FLAG_FWD = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  input  logic             set_flags,
  input  logic             br_valid,
  input  logic [1:0]       br_kind,
  input  logic [3:0]       br_cond,
  output logic [3:0]       flags_q,
  output logic             taken,
  output logic             taken_valid,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam bit               FWD_EN  = (FLAG_FWD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] KIND_BCOND = 2'b00;
  localparam logic [1:0] KIND_CBZ   = 2'b01;
  localparam logic [1:0] KIND_CBNZ  = 2'b10;
  localparam logic [1:0] KIND_B     = 2'b11;

  logic [3:0] live_flags;
  logic [3:0] eff_flags;
  logic       eff_n, eff_z, eff_v, eff_c;
  logic       cond_true;
  logic       decision;

  assign live_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};

  // Forwarding lets a B.cond fused with the flag-setting op see its result.
  assign eff_flags = (FWD_EN && set_flags) ? live_flags : flags_q;
  assign {eff_n, eff_z, eff_v, eff_c} = eff_flags;

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      4'h0: cond_true = eff_z;
      4'h1: cond_true = !eff_z;
      4'h2: cond_true = eff_c;
      4'h3: cond_true = !eff_c;
      4'h4: cond_true = eff_n;
      4'h5: cond_true = !eff_n;
      4'h6: cond_true = eff_v;
      4'h7: cond_true = !eff_v;
      4'h8: cond_true = eff_c && !eff_z;
      4'h9: cond_true = !eff_c || eff_z;
      4'hA: cond_true = (eff_n == eff_v);
      4'hB: cond_true = (eff_n != eff_v);
      4'hC: cond_true = !eff_z && (eff_n == eff_v);
      4'hD: cond_true = eff_z || (eff_n != eff_v);
      default: cond_true = 1'b1;  // AL and NV both always execute
    endcase
  end

  // CBZ/CBNZ test the register value passed straight through the ALU, so
  // they use the live zero flag, never flags_q.
  always_comb begin
    decision = 1'b0;
    case (br_kind)
      KIND_BCOND: decision = cond_true;
      KIND_CBZ:   decision = alu_zero;
      KIND_CBNZ:  decision = !alu_zero;
      KIND_B:     decision = 1'b1;
      default:    decision = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q      <= 4'b0000;
      taken        <= 1'b0;
      taken_valid  <= 1'b0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      if (set_flags) begin
        flags_q <= live_flags;
      end
      taken_valid <= br_valid;
      if (br_valid) begin
        taken <= decision;
        if (branch_count != CNT_MAX) begin
          branch_count <= branch_count + CNT_ONE;
        end
        if (decision && (taken_count != CNT_MAX)) begin
          taken_count <= taken_count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit. Three instances share one stimulus stream:
//   0: FLAG_FWD=1, CNT_W=16   1: FLAG_FWD=0, CNT_W=16   2: FLAG_FWD=1, CNT_W=2
module tb_flag_branch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic       set_flags, br_valid;
  logic [1:0] br_kind;
  logic [3:0] br_cond;

  logic [3:0]  fq0, fq1, fq2;
  logic        tk0, tk1, tk2;
  logic        tv0, tv1, tv2;
  logic [15:0] bc0, bc1, tc0, tc1;
  logic [1:0]  bc2, tc2;

  flag_branch_unit #(.FLAG_FWD(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out), .set_flags(set_flags),
    .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond), .flags_q(fq0),
    .taken(tk0), .taken_valid(tv0), .branch_count(bc0), .taken_count(tc0));

  flag_branch_unit #(.FLAG_FWD(0), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out), .set_flags(set_flags),
    .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond), .flags_q(fq1),
    .taken(tk1), .taken_valid(tv1), .branch_count(bc1), .taken_count(tc1));

  flag_branch_unit #(.FLAG_FWD(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out), .set_flags(set_flags),
    .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond), .flags_q(fq2),
    .taken(tk2), .taken_valid(tv2), .branch_count(bc2), .taken_count(tc2));

  // ---------------- scoreboard state ----------------
  int compares = 0;
  int errors   = 0;

  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];
  logic [0:0] exp_q2[$];

  // reference model, one slot per instance
  logic [3:0]  m_flags[3];
  logic        m_taken[3];
  logic        m_tv[3];
  int unsigned m_bc[3];
  int unsigned m_tc[3];
  bit          m_fwd[3] = '{1'b1, 1'b0, 1'b1};
  int unsigned m_max[3] = '{32'd65535, 32'd65535, 32'd3};
  bit          model_ok = 1'b0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ARM condition semantics: codes come in pairs, odd member is the inverse,
  // except 1110/1111 which are always true.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    {n, z, v, cy} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] != 3'd7 && c[0]) ? !base : base;
  endfunction

  task automatic push_exp(input int k, input logic t);
    case (k)
      0: exp_q0.push_back(t);
      1: exp_q1.push_back(t);
      default: exp_q2.push_back(t);
    endcase
  endtask

  task automatic check_state();
    logic [3:0]  fq[3];
    logic        tk[3];
    logic        tv[3];
    logic [15:0] bc[3];
    logic [15:0] tc[3];
    fq = '{fq0, fq1, fq2};
    tk = '{tk0, tk1, tk2};
    tv = '{tv0, tv1, tv2};
    bc = '{bc0, bc1, {14'b0, bc2}};
    tc = '{tc0, tc1, {14'b0, tc2}};
    for (int k = 0; k < 3; k++) begin
      chk("flags_q", k, {28'b0, fq[k]}, {28'b0, m_flags[k]});
      chk("taken_hold", k, {31'b0, tk[k]}, {31'b0, m_taken[k]});
      chk("taken_valid", k, {31'b0, tv[k]}, {31'b0, m_tv[k]});
      chk("branch_count", k, {16'b0, bc[k]}, m_bc[k]);
      chk("taken_count", k, {16'b0, tc[k]}, m_tc[k]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic [3:0] nzvc, input logic sf,
                       input logic bv, input logic [1:0] kind, input logic [3:0] cond);
    logic [3:0] eff;
    logic       d;
    @(negedge clk);
    if (model_ok) check_state();
    reset = rst;
    {alu_negative, alu_zero, alu_overflow, alu_carry_out} = nzvc;
    set_flags = sf;
    br_valid  = bv;
    br_kind   = kind;
    br_cond   = cond;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_flags[k] = 4'b0; m_taken[k] = 1'b0; m_tv[k] = 1'b0;
        m_bc[k] = 0; m_tc[k] = 0;
      end else begin
        eff = (m_fwd[k] && sf) ? nzvc : m_flags[k];
        case (kind)
          2'b00:   d = ref_cond(cond, eff);
          2'b01:   d = nzvc[2];
          2'b10:   d = !nzvc[2];
          default: d = 1'b1;
        endcase
        m_tv[k] = bv;
        if (bv) begin
          push_exp(k, d);
          m_taken[k] = d;
          if (m_bc[k] < m_max[k]) m_bc[k]++;
          if (d && m_tc[k] < m_max[k]) m_tc[k]++;
        end
        if (sf) m_flags[k] = nzvc;
      end
    end
    if (rst) model_ok = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'b0, 1'b0, 1'b0, 2'b00, 4'h0);
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int k, input logic tv, input logic tk);
    logic [0:0] e;
    int         sz;
    if (!tv) return;
    case (k)
      0: sz = exp_q0.size();
      1: sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    if (sz == 0) begin
      chk("unexpected_result", k, 32'd1, 32'd0);
      return;
    end
    case (k)
      0: e = exp_q0.pop_front();
      1: e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
    chk("taken", k, {31'b0, tk}, {31'b0, e});
  endtask

  always @(negedge clk) begin
    mon(0, tv0, tk0);
    mon(1, tv1, tk1);
    mon(2, tv2, tk2);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; alu_negative = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
    alu_carry_out = 1'b0; set_flags = 1'b0; br_valid = 1'b0; br_kind = 2'b00;
    br_cond = 4'h0;

    // reset with every input high: nothing latches, branch dropped
    drive(1'b1, 4'b1111, 1'b1, 1'b1, 2'b11, 4'hF);
    idle(1);
    @(negedge clk);
    chk("reset_flags", 0, {28'b0, fq0}, 32'd0);
    chk("reset_tv", 0, {31'b0, tv0}, 32'd0);
    chk("reset_bc", 0, {16'b0, bc0}, 32'd0);

    // 5-5: Z=1 C=1, then EQ / NE / HI
    drive(1'b0, 4'b0101, 1'b1, 1'b0, 2'b00, 4'h0);
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 4'h0);
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 4'h1);
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 4'h8);
    idle(1);

    // forwarding: flags_q=0, set N=1 V=0 with B.LT in the same cycle
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 2'b00, 4'h0);
    drive(1'b0, 4'b1000, 1'b1, 1'b1, 2'b00, 4'hB);
    idle(1);
    @(negedge clk);
    chk("fwd_lt", 0, {31'b0, tk0}, 32'd1);
    chk("nofwd_lt", 1, {31'b0, tk1}, 32'd0);

    // CBZ / CBNZ with alu_zero=1, no flag update
    drive(1'b0, 4'b0100, 1'b0, 1'b1, 2'b01, 4'h3);
    drive(1'b0, 4'b0100, 1'b0, 1'b1, 2'b10, 4'h0);
    // CBNZ with set_flags: flags still latch
    drive(1'b0, 4'b0011, 1'b1, 1'b1, 2'b10, 4'h5);
    idle(1);

    // saturation: 5 back-to-back B
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 4'h0);
    for (int i = 0; i < 5; i++) drive(1'b0, 4'b0000, 1'b0, 1'b1, 2'b11, 4'h0);
    idle(1);
    @(negedge clk);
    chk("sat_bc", 2, {30'b0, bc2}, 32'd3);
    chk("sat_tc", 2, {30'b0, tc2}, 32'd3);
    chk("nosat_bc", 0, {16'b0, bc0}, 32'd5);

    // branch in the cycle before reset: its result still emerges, but the
    // counters end cleared and no result follows reset
    drive(1'b0, 4'b0000, 1'b0, 1'b1, 2'b11, 4'h0);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 2'b00, 4'h0);
    idle(1);
    @(negedge clk);
    chk("post_reset_tv", 0, {31'b0, tv0}, 32'd0);
    chk("post_reset_bc", 0, {16'b0, bc0}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
    idle(3);
    @(negedge clk);
    chk("drain_q", 0, exp_q0.size(), 32'd0);
    chk("drain_q", 1, exp_q1.size(), 32'd0);
    chk("drain_q", 2, exp_q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
